// File: rtl/uart_tx_periph_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// transmit FSM states and STATUS bit positions.
package uart_tx_periph_pkg;

    localparam logic [31:0] UART_ADDR = 32'h4000_0000;

    localparam int unsigned BAUD_W   = 16;
    localparam int unsigned BIT_IDXW = 3;

    localparam int unsigned STAT_BUSY_BIT  = 0;
    localparam int unsigned STAT_FULL_BIT  = 1;
    localparam int unsigned STAT_EMPTY_BIT = 2;
    localparam int unsigned STAT_OVF_BIT   = 3;

    typedef enum logic [1:0] {
        UART_TXDATA = 2'd0,
        UART_STATUS = 2'd1,
        UART_BAUD   = 2'd2,
        UART_RSVD   = 2'd3
    } type_uart_reg;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } type_uart_state;

endpackage

// File: rtl/uart_tx_fifo.sv
// TX byte FIFO with extra-MSB pointers; a push while full is accepted only
// when a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_c_o,
    output logic             full_c_o,
    output logic             empty_c_o,
    output logic             empty_nxt_c_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    assign full_c_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_c_o = (wr_ptr_q == rd_ptr_q);
    assign rdata_c_o = mem_q[rd_ptr_q[AW-1:0]];

    assign pop_ok  = pop_i & ~empty_c_o;
    assign push_ok = push_i & (~full_c_o | pop_ok);

    assign wr_ptr_d      = wr_ptr_q + PW'(push_ok);
    assign rd_ptr_d      = rd_ptr_q + PW'(pop_ok);
    assign empty_nxt_c_o = (wr_ptr_d == rd_ptr_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: register decode, BAUD_DIV register,
// baud counter and transmit FSM feeding from a byte FIFO.
module uart_tx_periph
    import uart_tx_periph_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned BAUD_DIV_RST = 868
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  uart_sel,
    input  logic                  dbus_we,
    input  logic [DATA_WIDTH-1:0] dbus_addr,
    input  logic [DATA_WIDTH-1:0] dbus_wdata,
    output logic [DATA_WIDTH-1:0] dbus_rdata,
    output logic                  tx,
    output logic                  tx_irq
);
    type_uart_state      state_q, state_d;
    type_uart_reg        reg_sel;
    logic [BAUD_W-1:0]   baud_q, cnt_q, cnt_d, div_q, div_d, baud_eff;
    logic [7:0]          shift_q, shift_d, fifo_rdata;
    logic [BIT_IDXW-1:0] bit_idx_q, bit_idx_d;
    logic                tx_q, tx_d, irq_q, irq_d, ovf_q, ovf_d;
    logic                wr_en, push, pop, fifo_full, fifo_empty, fifo_empty_nxt;
    logic                bit_done, busy;
    logic                unused_ok;

    assign unused_ok = ^{dbus_addr[DATA_WIDTH-1:4], dbus_addr[1:0], dbus_wdata[DATA_WIDTH-1:16]};

    assign reg_sel  = type_uart_reg'(dbus_addr[3:2]);
    assign wr_en    = uart_sel & dbus_we;
    assign push     = wr_en & (reg_sel == UART_TXDATA);
    assign busy     = (state_q != UART_IDLE);
    assign baud_eff = (baud_q == '0) ? BAUD_W'(1) : baud_q;
    assign bit_done = (cnt_q == div_q - BAUD_W'(1));
    assign tx       = tx_q;
    assign tx_irq   = irq_q;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .push_i        (push),
        .pop_i         (pop),
        .wdata_i       (dbus_wdata[7:0]),
        .rdata_c_o     (fifo_rdata),
        .full_c_o      (fifo_full),
        .empty_c_o     (fifo_empty),
        .empty_nxt_c_o (fifo_empty_nxt)
    );

    // Load data path: combinational, zero for stores and unselected cycles.
    always_comb begin
        dbus_rdata = '0;
        if (uart_sel && !dbus_we) begin
            case (reg_sel)
                UART_STATUS: begin
                    dbus_rdata[STAT_BUSY_BIT]  = busy;
                    dbus_rdata[STAT_FULL_BIT]  = fifo_full;
                    dbus_rdata[STAT_EMPTY_BIT] = fifo_empty;
                    dbus_rdata[STAT_OVF_BIT]   = ovf_q;
                end
                UART_BAUD: dbus_rdata[BAUD_W-1:0] = baud_q;
                default:   dbus_rdata = '0;
            endcase
        end
    end

    // Transmit FSM; a frame start (from IDLE or straight out of STOP) pops
    // the FIFO and latches the divisor for the whole frame.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        pop       = 1'b0;
        case (state_q)
            UART_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    div_d   = baud_eff;
                    cnt_d   = '0;
                    state_d = UART_START;
                end
            end
            UART_START: begin
                if (bit_done) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = UART_DATA;
                end else begin
                    cnt_d = cnt_q + BAUD_W'(1);
                end
            end
            UART_DATA: begin
                if (bit_done) begin
                    cnt_d     = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + BIT_IDXW'(1);
                    if (bit_idx_q == BIT_IDXW'(7)) begin
                        state_d = UART_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + BAUD_W'(1);
                end
            end
            UART_STOP: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        div_d   = baud_eff;
                        state_d = UART_START;
                    end else begin
                        state_d = UART_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + BAUD_W'(1);
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    always_comb begin
        case (state_d)
            UART_START: tx_d = 1'b0;
            UART_DATA:  tx_d = shift_d[0];
            default:    tx_d = 1'b1;
        endcase
        irq_d = fifo_empty_nxt & (state_d == UART_IDLE);
        ovf_d = ovf_q;
        if (wr_en && (reg_sel == UART_STATUS)) begin
            ovf_d = 1'b0;
        end else if (push && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= UART_IDLE;
            cnt_q     <= '0;
            div_q     <= BAUD_W'(1);
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            irq_q     <= 1'b1;
            ovf_q     <= 1'b0;
            baud_q    <= BAUD_W'(BAUD_DIV_RST);
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            irq_q     <= irq_d;
            ovf_q     <= ovf_d;
            if (wr_en && (reg_sel == UART_BAUD)) begin
                baud_q <= dbus_wdata[BAUD_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Scoreboard bench for uart_tx_periph: stores queue expected bytes, a line
// monitor decodes each frame on tx and checks bits and timing.
module tb_uart_tx_periph;
    localparam int unsigned DW       = 32;
    localparam int unsigned BAUD_RST = 868;

    logic          clk, rst_n, uart_sel, dbus_we;
    logic [DW-1:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic          tx, tx_irq;

    int            vectors     = 0;
    int            miscompares = 0;
    logic [7:0]    exp_q[$];
    logic [15:0]   model_baud;

    uart_tx_periph #(
        .DATA_WIDTH   (DW),
        .FIFO_DEPTH   (8),
        .BAUD_DIV_RST (BAUD_RST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_sel   (uart_sel),
        .dbus_we    (dbus_we),
        .dbus_addr  (dbus_addr),
        .dbus_wdata (dbus_wdata),
        .dbus_rdata (dbus_rdata),
        .tx         (tx),
        .tx_irq     (tx_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // One-cycle store; a TXDATA store queues the byte unless it is expected to be dropped.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input bit drop, output logic [31:0] rd);
        @(negedge clk);
        uart_sel = 1'b1; dbus_we = 1'b1; dbus_addr = addr; dbus_wdata = data;
        #1 rd = dbus_rdata;
        @(posedge clk);
        #1;
        uart_sel = 1'b0; dbus_we = 1'b0;
        if (addr[3:2] == 2'd0 && !drop) exp_q.push_back(data[7:0]);
        if (addr[3:2] == 2'd2) model_baud = data[15:0];
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rd;
        bus_write(addr, data, 1'b0, rd);
    endtask

    task automatic bus_read(input logic sel, input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        uart_sel = sel; dbus_we = 1'b0; dbus_addr = addr;
        #1 data = dbus_rdata;
        @(posedge clk);
        #1 uart_sel = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(1'b1, addr, d);
        check(name, d, exp);
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (tx_irq === 1'b1) break;
        end
        check(name, 32'(tx_irq), 32'd1);
    endtask

    // Line monitor: each frame is 10 bits of max(divisor,1) cycles, where the
    // divisor is whatever BAUD_DIV held when the frame was launched.
    initial begin : monitor
        logic [15:0] last_baud;
        logic [9:0]  frame, got_bits;
        logic [7:0]  b;
        int          d, bad;
        bit          aborted;
        last_baud = 16'(BAUD_RST);
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_start: got start bit expected idle line at %0t", $time);
                    while (tx === 1'b0 && rst_n === 1'b1) @(negedge clk);
                end else begin
                    b        = exp_q.pop_front();
                    d        = (last_baud == 16'd0) ? 1 : int'(last_baud);
                    frame    = {1'b1, b, 1'b0};
                    got_bits = '0;
                    bad      = 0;
                    aborted  = 1'b0;
                    for (int k = 0; k < 10 * d; k++) begin
                        if (k > 0) @(negedge clk);
                        if (rst_n !== 1'b1) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (k % d == 0) got_bits[k / d] = tx;
                        if (tx !== frame[k / d]) bad++;
                    end
                    if (!aborted) begin
                        vectors++;
                        if (bad != 0) begin
                            miscompares++;
                            $display("FAIL frame_%02h: got bits 0x%03h (%0d bad cycles) expected 0x%03h div %0d",
                                     b, got_bits, bad, frame, d);
                        end
                    end
                end
            end
            last_baud = model_baud;
        end
    end

    initial begin : stimulus
        logic [31:0] d;
        logic [7:0]  byte_v;
        int          n;
        rst_n = 1'b0; uart_sel = 1'b0; dbus_we = 1'b0; dbus_addr = '0; dbus_wdata = '0;
        model_baud = 16'(BAUD_RST);
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_irq", 32'(tx_irq), 32'd1);
        #2 rst_n = 1'b1;
        read_check("reset_status", 32'h4, 32'h4);
        read_check("reset_baud", 32'h8, 32'(BAUD_RST));

        // Single 0xA5 frame at 4 clks/bit, start bit two cycles after the store.
        wr(32'h8, 32'd4);
        wr(32'h0, 32'hA5);
        @(negedge clk);
        check("pop_cycle_tx", 32'(tx), 32'd1);
        @(negedge clk);
        check("start_cycle_tx", 32'(tx), 32'd0);
        read_check("busy_status", 32'h4, 32'h5);
        check("busy_irq", 32'(tx_irq), 32'd0);
        wait_idle("drain_a5", 200);
        read_check("idle_status", 32'h4, 32'h4);

        // Fill: nine back-to-back pushes fit, tenth overflows.
        wr(32'h8, 32'd1);
        for (int i = 0; i < 9; i++) wr(32'h0, 32'(8'h10 + i));
        read_check("full_no_ovf", 32'h4, 32'h3);
        bus_write(32'h0, 32'hEE, 1'b1, d);
        read_check("overflow_set", 32'h4, 32'hB);
        wr(32'h4, 32'h0);
        read_check("overflow_clr", 32'h4, 32'h1);
        wait_idle("drain_fill", 2000);

        // Divisor change mid-frame applies only to the following frame.
        wr(32'h8, 32'd8);
        wr(32'h0, 32'h5A);
        repeat (20) @(negedge clk);
        wr(32'h8, 32'd2);
        wr(32'h0, 32'hC3);
        wait_idle("drain_divchg", 400);
        read_check("baud_2", 32'h8, 32'd2);

        // Divisor zero behaves as one.
        wr(32'h8, 32'd0);
        wr(32'h0, 32'hFF);
        wait_idle("drain_div0", 100);
        read_check("baud_0", 32'h8, 32'd0);

        // Randomised bursts with random divisors and gaps.
        for (int r = 0; r < 4; r++) begin
            d = 32'($urandom_range(0, 3));
            wr(32'h8, d);
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                byte_v = 8'($urandom);
                wr(32'h0, {24'($urandom), byte_v});
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_idle("drain_rand", 1000);
            read_check("baud_rand", 32'h8, d & 32'hFFFF);
        end

        // Reset in the middle of DATA bit 3.
        wr(32'h8, 32'd4);
        wr(32'h0, 32'h3C);
        repeat (19) @(negedge clk);
        check("midframe_irq", 32'(tx_irq), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_irq", 32'(tx_irq), 32'd1);
        exp_q.delete();
        model_baud = 16'(BAUD_RST);
        read_check("rst_status", 32'h4, 32'h4);
        #2 rst_n = 1'b1;
        read_check("post_rst_baud", 32'h8, 32'(BAUD_RST));
        read_check("post_rst_status", 32'h4, 32'h4);
        check("post_rst_irq", 32'(tx_irq), 32'd1);

        // Unselected / reserved accesses.
        bus_read(1'b0, 32'h4, d);
        check("unsel_load", d, 32'h0);
        read_check("rsvd_load", 32'hC, 32'h0);
        bus_write(32'hC, 32'hFFFF_FFFF, 1'b0, d);
        check("store_rdata", d, 32'h0);
        read_check("rsvd_status", 32'h4, 32'h4);
        read_check("rsvd_baud", 32'h8, 32'(BAUD_RST));
        repeat (20) @(negedge clk);
        check("rsvd_irq", 32'(tx_irq), 32'd1);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
